line_engine: RTL and testbench
==============================

Name: line_engine

Overview:
- Hardware line rasterizer: the responder on the CPU's checkpoint-3 line interface (line_color/line_point/line_*_valid/line_trigger/line_ready).
- Latches endpoint and colour writes from the CPU. On trigger, walks an all-octant Bresenham line and issues one 32-bit frame-buffer pixel write per point through a valid/ready write port to the memory arbiter.
- Sits beside the filler engine in the graphics subsystem.

Parameters:
- FB_BASE, 32'h1000_0000: frame-buffer base byte address. Bits [21:0] must be zero.
- SCREEN_W, 800: visible width. Pixels with x >= SCREEN_W are clipped.
- SCREEN_H, 600: visible height. Pixels with y >= SCREEN_H are clipped.

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- line_color  in  32  pixel colour. Bits [23:0] are used; bits [31:24] are written as 0.
- line_point  in  10  coordinate value for the *_valid strobes
- line_color_valid  in  1  latch line_color into colour register
- line_x0_valid  in  1  latch line_point into x0
- line_y0_valid  in  1  latch line_point into y0
- line_x1_valid  in  1  latch line_point into x1
- line_y1_valid  in  1  latch line_point into y1
- line_trigger  in  1  start drawing; honoured only when line_ready=1
- line_ready  out  1  engine idle and able to accept a trigger
- fb_wr_valid  out  1  pixel write request
- fb_wr_ready  in  1  arbiter accepts the request this cycle
- fb_wr_addr  out  32  byte address: FB_BASE | {y[9:0], x[9:0], 2'b00}
- fb_wr_data  out  32  {8'h00, colour[23:0]}

Behaviour:
- Reset values: line_ready=1, fb_wr_valid=0, fb_wr_addr=0, fb_wr_data=0; all latch registers = 0; state=IDLE.
- Reset mid-line: aborts the line. fb_wr_valid=0 on the cycle after rst is sampled; no further writes are issued.
- Latch registers:
  - Each *_valid strobe loads its register at the clock edge, in any state.
  - Multiple strobes in one cycle are all honoured.
  - A drawing in progress uses the snapshot taken at trigger, so register writes while busy affect only the next line.
- States:
  - IDLE: line_ready=1. If line_trigger, snapshot x0, y0, x1, y1 and colour, then go to SETUP.
  - SETUP (1 cycle): compute
    - dx=|x1-x0|, dy=|y1-y0| (11-bit unsigned)
    - sx=(x1>=x0)?+1:-1, sy=(y1>=y0)?+1:-1
    - err=dx-dy (13-bit signed)
    - current point (x,y)=(x0,y0)
    - then go to DRAW.
  - DRAW: each step has e2=2*err (14-bit signed).
    - c1 = (e2 >= -dy), c2 = (e2 <= dx), both evaluated from the same err.
    - err_next = err - (c1?dy:0) + (c2?dx:0); x += c1?sx:0; y += c2?sy:0.
    - Last point: (x,y)==(x1,y1). After it is consumed, go to IDLE.
- line_ready is 0 from the cycle after an accepted trigger until the cycle after the last point is consumed.
- Latency: trigger sampled at edge T → SETUP in cycle T+1 → first fb_wr_valid in cycle T+2.
- Write handshake:
  - In DRAW, for an on-screen point, assert fb_wr_valid with that point's addr/data.
  - The point is consumed on a cycle with valid && ready, then the stepper advances.
  - While valid=1 and ready=0, addr, data and valid are held stable. Valid never drops without a handshake, except on reset.
- Clipped points (x>=SCREEN_W or y>=SCREEN_H): fb_wr_valid=0, point consumed in 1 cycle, no write issued.
- Throughput: 1 pixel/cycle while fb_wr_ready=1.
- Trigger while line_ready=0 is ignored; it is not queued.
- Degenerate line (x0==x1, y0==y1): exactly one write.
- Coordinates are unsigned 10-bit and never wrap, because stepping stops exactly at the endpoint.

Decomposition:
- Shared package gfx_pkg:
  - state encoding (IDLE, SETUP, DRAW)
  - SCREEN_W / SCREEN_H defaults
  - coordinate width (10), error width (13)
  - fb address packing helper constant: row shift 12
- One sub-module, line_stepper: combinational Bresenham step.
  - In: x, y, err, dx, dy, sx, sy.
  - Out: x_next, y_next, err_next, last.
  - line_engine owns the FSM, latches, handshake and clipping.

Test Plan:
- Horizontal line: (0,0)->(3,0), colour 0x00FF0000, ready tied 1 → 4 writes on consecutive cycles.
  - addr 0x10000000, 0x10000004, 0x10000008, 0x1000000C; data 0x00FF0000.
  - line_ready returns to 1 on the cycle after the last write.
- Steep line: (0,0)->(1,3) → writes (0,0), (0,1), (1,2), (1,3); last addr 0x10003004.
- Reverse diagonal: (3,3)->(0,0) → (3,3), (2,2), (1,1), (0,0); degenerate (5,5)->(5,5) → exactly one write, addr 0x10005014.
- Backpressure: ready low 3 cycles at the 2nd pixel of (0,0)->(3,0) → valid/addr/data held stable; total 4 writes, none duplicated or dropped.
- Clip: (798,0)->(801,0) → 2 writes (x=798,799), 2 silent cycles; trigger pulsed mid-line ignored (still exactly one line drawn).
- Reset during 3rd pixel of a 10-pixel line → fb_wr_valid=0 and line_ready=1 the next cycle; no further writes; a fresh trigger draws correctly.

Source files
------------

// File: rtl/gfx_pkg.sv
// rtl/gfx_pkg.sv - shared graphics types, screen limits and frame-buffer address packing
// Contents:
//   line_state_t         line engine FSM encoding (IDLE, SETUP, DRAW)
//   SCREEN_W/H_DEF       default visible area
//   COORD_W, ERR_W, E2_W coordinate, Bresenham error and doubled-error widths
//   ROW_SHIFT, COL_SHIFT byte-address placement of y and x
//   fb_pack()            base | {y, x, 2'b00}
package gfx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_DRAW  = 2'd2
   } line_state_t;

   localparam int SCREEN_W_DEF = 800;
   localparam int SCREEN_H_DEF = 600;

   localparam int COORD_W   = 10;
   localparam int ERR_W     = 13;
   localparam int E2_W      = 14;
   localparam int ROW_SHIFT = 12;
   localparam int COL_SHIFT = 2;

   // Base bits [21:0] are zero, so OR-ing the pixel offset is a plain add.
   function automatic logic [31:0] fb_pack(input logic [31:0]        base,
                                           input logic [COORD_W-1:0] x,
                                           input logic [COORD_W-1:0] y);
      logic [31:0] off;
      off = ({22'd0, y} << ROW_SHIFT) | ({22'd0, x} << COL_SHIFT);
      return base | off;
   endfunction

endpackage

// File: rtl/line_engine_if.sv
// rtl/line_engine_if.sv - CPU line-command and frame-buffer write signals of the line engine
// Signals:
//   line_color[31:0], line_point[9:0]        CPU data
//   line_{color,x0,y0,x1,y1}_valid           CPU register strobes
//   line_trigger / line_ready                start request / engine idle
//   fb_wr_valid, fb_wr_ready                 pixel write handshake to arbiter
//   fb_wr_addr[31:0], fb_wr_data[31:0]       pixel write payload
// Modports:
//   slave  - the line engine (responder)
//   master - CPU plus memory arbiter side
interface line_engine_if;
   import gfx_pkg::*;

   logic [31:0]        line_color;
   logic [COORD_W-1:0] line_point;
   logic               line_color_valid;
   logic               line_x0_valid;
   logic               line_y0_valid;
   logic               line_x1_valid;
   logic               line_y1_valid;
   logic               line_trigger;
   logic               line_ready;
   logic               fb_wr_valid;
   logic               fb_wr_ready;
   logic [31:0]        fb_wr_addr;
   logic [31:0]        fb_wr_data;

   modport slave (
      input  line_color, line_point,
      input  line_color_valid, line_x0_valid, line_y0_valid,
      input  line_x1_valid, line_y1_valid, line_trigger,
      input  fb_wr_ready,
      output line_ready, fb_wr_valid, fb_wr_addr, fb_wr_data
   );

   modport master (
      output line_color, line_point,
      output line_color_valid, line_x0_valid, line_y0_valid,
      output line_x1_valid, line_y1_valid, line_trigger,
      output fb_wr_ready,
      input  line_ready, fb_wr_valid, fb_wr_addr, fb_wr_data
   );

endinterface

// File: rtl/line_stepper.sv
// rtl/line_stepper.sv - combinational all-octant Bresenham step
// Ports:
//   x, y      in   current point
//   x1, y1    in   line end point
//   err       in   current error term (signed)
//   dx, dy    in   |x1-x0|, |y1-y0|
//   sx, sy    in   step direction per axis: 1 = decrement, 0 = increment
//   x_next, y_next, err_next  out  stepped point and error
//   last      out  current point is the end point
module line_stepper
   import gfx_pkg::*;
(
   input  logic [COORD_W-1:0]       x,
   input  logic [COORD_W-1:0]       y,
   input  logic [COORD_W-1:0]       x1,
   input  logic [COORD_W-1:0]       y1,
   input  logic signed [ERR_W-1:0] err,
   input  logic [COORD_W:0]         dx,
   input  logic [COORD_W:0]         dy,
   input  logic                     sx,
   input  logic                     sy,
   output logic [COORD_W-1:0]       x_next,
   output logic [COORD_W-1:0]       y_next,
   output logic signed [ERR_W-1:0] err_next,
   output logic                     last
);

   logic signed [E2_W-1:0]  e2;
   logic signed [E2_W-1:0]  dx_e2;
   logic signed [E2_W-1:0]  dy_e2;
   logic signed [ERR_W-1:0] dx_e;
   logic signed [ERR_W-1:0] dy_e;
   logic                    c1;
   logic                    c2;

   always_comb begin
      e2    = $signed({err, 1'b0});
      dx_e2 = $signed({3'b000, dx});
      dy_e2 = $signed({3'b000, dy});
      dx_e  = $signed({2'b00, dx});
      dy_e  = $signed({2'b00, dy});

      // Both decisions come from the same error value, so a diagonal
      // step moves x and y together.
      c1 = (e2 >= -dy_e2);
      c2 = (e2 <= dx_e2);

      err_next = err - (c1 ? dy_e : 13'sd0) + (c2 ? dx_e : 13'sd0);
      x_next   = c1 ? (sx ? x - 10'd1 : x + 10'd1) : x;
      y_next   = c2 ? (sy ? y - 10'd1 : y + 10'd1) : y;
      last     = (x == x1) && (y == y1);
   end

endmodule

// File: rtl/line_engine.sv
// rtl/line_engine.sv - Bresenham line rasterizer issuing one frame-buffer write per pixel
// Parameters:
//   FB_BASE   frame-buffer base byte address, bits [21:0] zero
//   SCREEN_W  pixels with x >= SCREEN_W are skipped
//   SCREEN_H  pixels with y >= SCREEN_H are skipped
// Ports:
//   clk   in  clock
//   rst   in  synchronous active-high reset (aborts a line in progress)
//   bus   slave side of line_engine_if: CPU latches/trigger, pixel write port
module line_engine
   import gfx_pkg::*;
#(
   parameter logic [31:0] FB_BASE  = 32'h1000_0000,
   parameter int          SCREEN_W = SCREEN_W_DEF,
   parameter int          SCREEN_H = SCREEN_H_DEF
)(
   input  logic          clk,
   input  logic          rst,
   line_engine_if.slave  bus
);

   localparam logic [COORD_W:0] W_LIM = (COORD_W+1)'(SCREEN_W);
   localparam logic [COORD_W:0] H_LIM = (COORD_W+1)'(SCREEN_H);

   line_state_t state, state_nxt;

   // CPU-visible latches
   logic [31:0]        col_r;
   logic [COORD_W-1:0] x0_r, y0_r, x1_r, y1_r;

   // Per-line working set, captured at trigger so CPU writes only
   // affect the next line.
   logic [31:0]             line_col;
   logic [COORD_W-1:0]      cur_x, cur_y, end_x, end_y;
   logic [COORD_W:0]        dx, dy;
   logic                    sx, sy;
   logic signed [ERR_W-1:0] err;

   logic [COORD_W:0]        dx_c, dy_c;
   logic signed [ERR_W-1:0] err_init;

   logic [COORD_W-1:0]      x_step, y_step;
   logic signed [ERR_W-1:0] err_step;
   logic                    last;

   logic on_screen;
   logic ready_c, valid_c, take_trig, advance;

   line_stepper u_stepper (
      .x        (cur_x),
      .y        (cur_y),
      .x1       (end_x),
      .y1       (end_y),
      .err      (err),
      .dx       (dx),
      .dy       (dy),
      .sx       (sx),
      .sy       (sy),
      .x_next   (x_step),
      .y_next   (y_step),
      .err_next (err_step),
      .last     (last)
   );

   always_comb begin
      dx_c     = (end_x >= cur_x) ? {1'b0, end_x} - {1'b0, cur_x}
                                  : {1'b0, cur_x} - {1'b0, end_x};
      dy_c     = (end_y >= cur_y) ? {1'b0, end_y} - {1'b0, cur_y}
                                  : {1'b0, cur_y} - {1'b0, end_y};
      err_init = $signed({2'b00, dx_c}) - $signed({2'b00, dy_c});
      on_screen = ({1'b0, cur_x} < W_LIM) && ({1'b0, cur_y} < H_LIM);
   end

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ready_c   = 1'b0;
      valid_c   = 1'b0;
      take_trig = 1'b0;
      advance   = 1'b0;
      case (state)
         ST_IDLE: begin
            ready_c = 1'b1;
            if (bus.line_trigger) begin
               take_trig = 1'b1;
               state_nxt = ST_SETUP;
            end
         end
         ST_SETUP: state_nxt = ST_DRAW;
         ST_DRAW: begin
            // Off-screen points are consumed silently in one cycle.
            valid_c = on_screen;
            advance = !on_screen || bus.fb_wr_ready;
            if (advance && last) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         col_r    <= '0;
         x0_r     <= '0;
         y0_r     <= '0;
         x1_r     <= '0;
         y1_r     <= '0;
         line_col <= '0;
         cur_x    <= '0;
         cur_y    <= '0;
         end_x    <= '0;
         end_y    <= '0;
         dx       <= '0;
         dy       <= '0;
         sx       <= 1'b0;
         sy       <= 1'b0;
         err      <= '0;
      end else begin
         if (bus.line_color_valid) col_r <= bus.line_color;
         if (bus.line_x0_valid)    x0_r  <= bus.line_point;
         if (bus.line_y0_valid)    y0_r  <= bus.line_point;
         if (bus.line_x1_valid)    x1_r  <= bus.line_point;
         if (bus.line_y1_valid)    y1_r  <= bus.line_point;

         if (take_trig) begin
            line_col <= col_r;
            cur_x    <= x0_r;
            cur_y    <= y0_r;
            end_x    <= x1_r;
            end_y    <= y1_r;
         end

         if (state == ST_SETUP) begin
            dx  <= dx_c;
            dy  <= dy_c;
            sx  <= (end_x < cur_x);
            sy  <= (end_y < cur_y);
            err <= err_init;
         end

         // Holding the point on the last step keeps coordinates from
         // stepping past the end point.
         if (advance && !last) begin
            cur_x <= x_step;
            cur_y <= y_step;
            err   <= err_step;
         end
      end
   end

   assign bus.line_ready  = ready_c;
   assign bus.fb_wr_valid = valid_c;
   assign bus.fb_wr_addr  = valid_c ? fb_pack(FB_BASE, cur_x, cur_y) : 32'd0;
   assign bus.fb_wr_data  = valid_c ? (line_col & 32'h00FF_FFFF) : 32'd0;

endmodule

// File: tb/tb_line_engine.sv
// tb/tb_line_engine.sv - scoreboard bench for line_engine
module tb_line_engine;
   import gfx_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   line_engine_if bus ();

   line_engine #(
      .FB_BASE  (32'h1000_0000),
      .SCREEN_W (800),
      .SCREEN_H (600)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;
   logic [63:0] exp_q[$];
   logic        mon_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] addr, input logic [31:0] data);
      exp_q.push_back({addr, data});
   endtask

   task automatic load_line(input logic [9:0] x0, input logic [9:0] y0,
                            input logic [9:0] x1, input logic [9:0] y1,
                            input logic [31:0] col);
      // Colour and x0 share a cycle to exercise simultaneous strobes.
      bus.line_color = col;  bus.line_color_valid = 1'b1;
      bus.line_point = x0;   bus.line_x0_valid    = 1'b1;
      tick();
      bus.line_color_valid = 1'b0; bus.line_x0_valid = 1'b0;
      bus.line_point = y0; bus.line_y0_valid = 1'b1; tick(); bus.line_y0_valid = 1'b0;
      bus.line_point = x1; bus.line_x1_valid = 1'b1; tick(); bus.line_x1_valid = 1'b0;
      bus.line_point = y1; bus.line_y1_valid = 1'b1; tick(); bus.line_y1_valid = 1'b0;
   endtask

   task automatic fire();
      bus.line_trigger = 1'b1;
      tick();
      bus.line_trigger = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (bus.line_ready !== 1'b1 && n < 300) begin
         tick();
         n++;
      end
      chk({name, "_idle"}, {31'd0, bus.line_ready}, 32'd1);
      tick();
   endtask

   // Monitor: pops the scoreboard on each accepted write and checks
   // that a stalled request stays put until accepted.
   logic        hold_pend = 1'b0;
   logic [31:0] hold_a, hold_d;
   logic [63:0] e;

   always @(negedge clk) begin
      if (mon_en) begin
         if (hold_pend) begin
            chk("hold_valid", {31'd0, bus.fb_wr_valid}, 32'd1);
            chk("hold_addr", bus.fb_wr_addr, hold_a);
            chk("hold_data", bus.fb_wr_data, hold_d);
         end
         hold_pend = 1'b0;
         if (bus.fb_wr_valid && bus.fb_wr_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_write: got addr %h data %h, expected no write", bus.fb_wr_addr, bus.fb_wr_data);
            end else begin
               e = exp_q.pop_front();
               chk("wr_addr", bus.fb_wr_addr, e[63:32]);
               chk("wr_data", bus.fb_wr_data, e[31:0]);
            end
         end else if (bus.fb_wr_valid) begin
            hold_pend = 1'b1;
            hold_a    = bus.fb_wr_addr;
            hold_d    = bus.fb_wr_data;
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      bus.line_color = '0;  bus.line_point = '0;
      bus.line_color_valid = 1'b0; bus.line_x0_valid = 1'b0; bus.line_y0_valid = 1'b0;
      bus.line_x1_valid = 1'b0; bus.line_y1_valid = 1'b0; bus.line_trigger = 1'b0;
      bus.fb_wr_ready = 1'b1;
      tick(); tick();
      chk("rst_ready", {31'd0, bus.line_ready}, 32'd1);
      chk("rst_valid", {31'd0, bus.fb_wr_valid}, 32'd0);
      chk("rst_addr", bus.fb_wr_addr, 32'd0);
      chk("rst_data", bus.fb_wr_data, 32'd0);
      rst = 1'b0;
      mon_en = 1'b1;
      tick();

      // Horizontal line with cycle-exact latency and ready return
      load_line(10'd0, 10'd0, 10'd3, 10'd0, 32'h00FF_0000);
      push(32'h1000_0000, 32'h00FF_0000);
      push(32'h1000_0004, 32'h00FF_0000);
      push(32'h1000_0008, 32'h00FF_0000);
      push(32'h1000_000C, 32'h00FF_0000);
      fire();
      chk("h_setup_ready", {31'd0, bus.line_ready}, 32'd0);
      chk("h_setup_valid", {31'd0, bus.fb_wr_valid}, 32'd0);
      tick();
      chk("h_first_valid", {31'd0, bus.fb_wr_valid}, 32'd1);
      tick(); tick(); tick();
      chk("h_last_ready", {31'd0, bus.line_ready}, 32'd0);
      chk("h_last_addr", bus.fb_wr_addr, 32'h1000_000C);
      tick();
      chk("h_done_ready", {31'd0, bus.line_ready}, 32'd1);
      chk("h_done_valid", {31'd0, bus.fb_wr_valid}, 32'd0);
      chk("h_q_empty", exp_q.size(), 32'd0);

      // Steep line; colour top byte must be dropped
      load_line(10'd0, 10'd0, 10'd1, 10'd3, 32'hAB12_3456);
      push(32'h1000_0000, 32'h0012_3456);
      push(32'h1000_1000, 32'h0012_3456);
      push(32'h1000_2004, 32'h0012_3456);
      push(32'h1000_3004, 32'h0012_3456);
      fire();
      wait_idle("steep");
      chk("steep_q_empty", exp_q.size(), 32'd0);

      // Reverse diagonal
      load_line(10'd3, 10'd3, 10'd0, 10'd0, 32'h0000_00FF);
      push(32'h1000_300C, 32'h0000_00FF);
      push(32'h1000_2008, 32'h0000_00FF);
      push(32'h1000_1004, 32'h0000_00FF);
      push(32'h1000_0000, 32'h0000_00FF);
      fire();
      wait_idle("rdiag");
      chk("rdiag_q_empty", exp_q.size(), 32'd0);

      // Degenerate single point
      load_line(10'd5, 10'd5, 10'd5, 10'd5, 32'h00C0_FFEE);
      push(32'h1000_5014, 32'h00C0_FFEE);
      fire();
      wait_idle("degen");
      chk("degen_q_empty", exp_q.size(), 32'd0);

      // Backpressure on the 2nd pixel for 3 cycles
      load_line(10'd0, 10'd0, 10'd3, 10'd0, 32'h0011_2233);
      push(32'h1000_0000, 32'h0011_2233);
      push(32'h1000_0004, 32'h0011_2233);
      push(32'h1000_0008, 32'h0011_2233);
      push(32'h1000_000C, 32'h0011_2233);
      fire();
      tick();
      tick();
      bus.fb_wr_ready = 1'b0;
      tick();
      chk("bp_stall_addr", bus.fb_wr_addr, 32'h1000_0004);
      tick(); tick();
      bus.fb_wr_ready = 1'b1;
      wait_idle("bp");
      chk("bp_q_empty", exp_q.size(), 32'd0);

      // Right-edge clipping with an ignored mid-line trigger
      load_line(10'd798, 10'd0, 10'd801, 10'd0, 32'h00AB_CDEF);
      push(32'h1000_0C78, 32'h00AB_CDEF);
      push(32'h1000_0C7C, 32'h00AB_CDEF);
      fire();
      tick();
      tick();
      tick();
      bus.line_trigger = 1'b1;
      chk("clip_x800_valid", {31'd0, bus.fb_wr_valid}, 32'd0);
      chk("clip_busy_ready", {31'd0, bus.line_ready}, 32'd0);
      tick();
      bus.line_trigger = 1'b0;
      chk("clip_x801_valid", {31'd0, bus.fb_wr_valid}, 32'd0);
      tick();
      chk("clip_done_ready", {31'd0, bus.line_ready}, 32'd1);
      tick(); tick(); tick();
      chk("clip_no_requeue", {31'd0, bus.line_ready}, 32'd1);
      chk("clip_q_empty", exp_q.size(), 32'd0);

      // Reset during the 3rd pixel of a 10-pixel line
      load_line(10'd0, 10'd0, 10'd9, 10'd0, 32'h0077_7777);
      push(32'h1000_0000, 32'h0077_7777);
      push(32'h1000_0004, 32'h0077_7777);
      push(32'h1000_0008, 32'h0077_7777);
      fire();
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      chk("rst_mid_valid", {31'd0, bus.fb_wr_valid}, 32'd0);
      chk("rst_mid_ready", {31'd0, bus.line_ready}, 32'd1);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      chk("rst_mid_q_empty", exp_q.size(), 32'd0);

      // Latches were cleared by reset: a bare trigger draws (0,0) in colour 0
      push(32'h1000_0000, 32'h0000_0000);
      fire();
      wait_idle("post_rst_zero");
      chk("post_rst_zero_q", exp_q.size(), 32'd0);

      // Fresh shallow line after reset
      load_line(10'd0, 10'd0, 10'd2, 10'd1, 32'h0044_5566);
      push(32'h1000_0000, 32'h0044_5566);
      push(32'h1000_1004, 32'h0044_5566);
      push(32'h1000_1008, 32'h0044_5566);
      fire();
      wait_idle("post_rst");
      chk("post_rst_q_empty", exp_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
